// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one downstream resource among PORTS requesters and produces a
//   registered one-hot grant suitable for driving a mux select.
//   Selection is fixed priority or round-robin (rotating after the last
//   grantee). Optionally a grant is held until its owner releases it, either
//   by dropping its request or by pulsing its acknowledge bit.
//
// Ports
//   clk            in   1               clock, all state on rising edge
//   rst_n          in   1               asynchronous active-low reset
//   request        in   PORTS           per-requester request, level
//   acknowledge    in   PORTS           per-requester release pulse
//   grant          out  PORTS           one-hot grant, registered
//   grant_valid    out  1               high while a grant is held
//   grant_encoded  out  $clog2(PORTS)   index of granted port, 0 when idle
module bus_arbiter #(
  parameter int PORTS             = 4,
  parameter int ARB_ROUND_ROBIN   = 1,
  parameter int ARB_BLOCK         = 1,
  parameter int ARB_BLOCK_ACK     = 1,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS-1:0]           request,
  input  logic [PORTS-1:0]           acknowledge,
  output logic [PORTS-1:0]           grant,
  output logic                       grant_valid,
  output logic [$clog2(PORTS)-1:0]   grant_encoded
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  state_t             r_state;
  logic [PORTS-1:0]   r_grant;
  logic [IDX_W-1:0]   r_enc;
  logic [IDX_W-1:0]   r_last;
  logic               r_last_vld;

  state_t             w_state_nxt;
  logic [PORTS-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]   w_enc_nxt;
  logic [IDX_W-1:0]   w_last_nxt;
  logic               w_last_vld_nxt;

  logic [PORTS-1:0]   w_mask;
  logic [PORTS-1:0]   w_masked;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_any;
  logic               w_release;

  // Highest-priority set bit of vec in encoder order. The loop runs from the
  // lowest-priority end so the last hit is the winner.
  function automatic logic [IDX_W-1:0] f_pick(input logic [PORTS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Ports strictly lower in priority than the last grantee. Empty until the
  // first grant after reset, so the first round-robin pick equals the fixed pick.
  function automatic logic [PORTS-1:0] f_rr_mask(input logic [IDX_W-1:0] last,
                                                 input logic            vld);
    logic [PORTS-1:0] m;
    m = '0;
    if (ARB_ROUND_ROBIN != 0 && vld) begin
      for (int i = 0; i < PORTS; i++) begin
        if (LSB_HIGH_PRIORITY != 0) m[i] = (i > int'(last));
        else                        m[i] = (i < int'(last));
      end
    end
    return m;
  endfunction

  always_comb begin
    w_mask    = f_rr_mask(r_last, r_last_vld);
    w_masked  = request & w_mask;
    w_arb_any = |request;
    w_arb_idx = (|w_masked) ? f_pick(w_masked) : f_pick(request);
  end

  // Decide whether the current holder gives up the resource this edge.
  // Idle or non-blocking operation always re-arbitrates.
  always_comb begin
    w_release = 1'b1;
    if (ARB_BLOCK != 0 && r_state == GRANTED) begin
      if (ARB_BLOCK_ACK != 0) w_release = acknowledge[r_enc];
      else                    w_release = !request[r_enc];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_enc_nxt      = r_enc;
    w_last_nxt     = r_last;
    w_last_vld_nxt = r_last_vld;
    if (w_release) begin
      if (w_arb_any) begin
        w_state_nxt            = GRANTED;
        w_grant_nxt            = '0;
        w_grant_nxt[w_arb_idx] = 1'b1;
        w_enc_nxt              = w_arb_idx;
        w_last_nxt             = w_arb_idx;
        w_last_vld_nxt         = 1'b1;
      end else begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_enc_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_enc      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_enc      <= w_enc_nxt;
      r_last     <= w_last_nxt;
      r_last_vld <= w_last_vld_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = (r_state == GRANTED);
  assign grant_encoded = r_enc;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Six arbiter instances in different configurations, each with its own
//   request/acknowledge inputs. A vector table drives one instance per entry;
//   expected outputs go through a scoreboard queue and are compared one cycle
//   later. Hand-written sequences cover reset during an active grant.
//   Instance map: 0 RR/block/ack, 1 RR/non-block, 2 fixed/non-block LSB,
//   3 fixed/non-block MSB, 4 RR/block/request-drop, 5 fixed/block/ack.
module tb_bus_arbiter;

  localparam int NDUT = 6;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a [NDUT];
  logic [3:0] ack_a [NDUT];
  logic [3:0] g_a   [NDUT];
  logic       v_a   [NDUT];
  logic [1:0] e_a   [NDUT];

  typedef struct {
    int         dut;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] g;
    logic       v;
    logic [1:0] e;
    string      nm;
  } vec_t;

  typedef struct {
    int         dut;
    logic [3:0] g;
    logic       v;
    logic [1:0] e;
    string      nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec;
  int   n_miss;

  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_rr_blk_ack (
    .clk(clk), .rst_n(rst_n), .request(req_a[0]), .acknowledge(ack_a[0]),
    .grant(g_a[0]), .grant_valid(v_a[0]), .grant_encoded(e_a[0]));
  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_rr_nb (
    .clk(clk), .rst_n(rst_n), .request(req_a[1]), .acknowledge(ack_a[1]),
    .grant(g_a[1]), .grant_valid(v_a[1]), .grant_encoded(e_a[1]));
  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_fx_nb (
    .clk(clk), .rst_n(rst_n), .request(req_a[2]), .acknowledge(ack_a[2]),
    .grant(g_a[2]), .grant_valid(v_a[2]), .grant_encoded(e_a[2]));
  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(0)) u_fx_nb_msb (
    .clk(clk), .rst_n(rst_n), .request(req_a[3]), .acknowledge(ack_a[3]),
    .grant(g_a[3]), .grant_valid(v_a[3]), .grant_encoded(e_a[3]));
  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0), .LSB_HIGH_PRIORITY(1)) u_rr_blk_req (
    .clk(clk), .rst_n(rst_n), .request(req_a[4]), .acknowledge(ack_a[4]),
    .grant(g_a[4]), .grant_valid(v_a[4]), .grant_encoded(e_a[4]));
  bus_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIORITY(1)) u_fx_blk_ack (
    .clk(clk), .rst_n(rst_n), .request(req_a[5]), .acknowledge(ack_a[5]),
    .grant(g_a[5]), .grant_valid(v_a[5]), .grant_encoded(e_a[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int d,
                       input logic [3:0] xg, input logic xv, input logic [1:0] xe);
    n_vec++;
    if (g_a[d] !== xg || v_a[d] !== xv || e_a[d] !== xe) begin
      n_miss++;
      $display("FAIL %s (dut%0d): got grant=%b valid=%b enc=%0d, expected grant=%b valid=%b enc=%0d",
               nm, d, g_a[d], v_a[d], e_a[d], xg, xv, xe);
    end
  endtask

  task automatic add(input int d, input logic [3:0] r, input logic [3:0] a,
                     input logic [3:0] g, input logic v, input logic [1:0] e,
                     input string nm);
    vec_t t;
    t.dut = d; t.req = r; t.ack = a; t.g = g; t.v = v; t.e = e; t.nm = nm;
    vecs.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    exp_t x;
    @(negedge clk);
    req_a[t.dut] = t.req;
    ack_a[t.dut] = t.ack;
    x.dut = t.dut; x.g = t.g; x.v = t.v; x.e = t.e; x.nm = t.nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard: queue empty, expected 1 entry");
    end else begin
      x = sb.pop_front();
      check(x.nm, x.dut, x.g, x.v, x.e);
    end
  endtask

  initial begin
    vec_t t;
    n_vec  = 0;
    n_miss = 0;

    // round-robin, non-blocking rotation and pointer behaviour
    add(1, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, "rr_nb_rot0");
    add(1, 4'b1111, 4'b0000, 4'b0010, 1'b1, 2'd1, "rr_nb_rot1");
    add(1, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, "rr_nb_rot2");
    add(1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 2'd3, "rr_nb_rot3");
    add(1, 4'b1111, 4'b0000, 4'b0001, 1'b1, 2'd0, "rr_nb_wrap");
    add(1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "rr_nb_idle");
    add(1, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2, "rr_nb_after_idle");
    add(1, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, "rr_nb_mask_empty");
    // fixed priority, LSB high
    add(2, 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, "fx_lsb_1010");
    add(2, 4'b1010, 4'b0000, 4'b0010, 1'b1, 2'd1, "fx_lsb_no_rotate");
    add(2, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, "fx_lsb_1000");
    add(2, 4'b0110, 4'b1111, 4'b0010, 1'b1, 2'd1, "fx_lsb_ack_ignored");
    add(2, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "fx_lsb_idle");
    // fixed priority, MSB high
    add(3, 4'b1010, 4'b0000, 4'b1000, 1'b1, 2'd3, "fx_msb_1010");
    add(3, 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1, "fx_msb_0011");
    add(3, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "fx_msb_idle");
    // RR, blocking, release on request drop
    add(4, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, "blk_req_first");
    add(4, 4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, "blk_req_hold_ack_ign");
    add(4, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, "blk_req_handoff");
    add(4, 4'b0011, 4'b0000, 4'b0010, 1'b1, 2'd1, "blk_req_no_preempt");
    add(4, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "blk_req_idle");
    // RR, blocking, release on acknowledge
    add(0, 4'b0101, 4'b0000, 4'b0001, 1'b1, 2'd0, "blk_ack_first");
    add(0, 4'b0101, 4'b0100, 4'b0001, 1'b1, 2'd0, "blk_ack_nonholder");
    add(0, 4'b0101, 4'b0001, 4'b0100, 1'b1, 2'd2, "blk_ack_handoff");
    add(0, 4'b0101, 4'b0000, 4'b0100, 1'b1, 2'd2, "blk_ack_hold");
    add(0, 4'b0000, 4'b0000, 4'b0100, 1'b1, 2'd2, "blk_ack_hold_no_req");
    add(0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, "blk_ack_to_idle");
    add(0, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "blk_ack_regrant");
    // fixed, blocking, release on acknowledge
    add(5, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, "fx_ack_first");
    add(5, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, "fx_ack_regrant");
    add(5, 4'b0011, 4'b0000, 4'b0001, 1'b1, 2'd0, "fx_ack_hold");
    add(5, 4'b0011, 4'b0001, 4'b0001, 1'b1, 2'd0, "fx_ack_regrant_prio");
    add(5, 4'b0010, 4'b0001, 4'b0010, 1'b1, 2'd1, "fx_ack_handoff");
    add(5, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, "fx_ack_idle");

    // reset with requests asserted: nothing granted
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      req_a[i] = 4'b1111;
      ack_a[i] = 4'b0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) check("reset_state", i, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) req_a[i] = 4'b0000;
    rst_n = 1'b1;

    foreach (vecs[k]) apply(vecs[k]);

    // asynchronous reset while a grant is held (instance 0 moves pointer to 2 first)
    t.dut = 0; t.req = 4'b0100; t.ack = 4'b0001; t.g = 4'b0100; t.v = 1'b1; t.e = 2'd2;
    t.nm = "pre_reset_grant";
    apply(t);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", 0, 4'b0000, 1'b0, 2'd0);
    req_a[0] = 4'b0000;
    ack_a[0] = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    // cleared pointer: first pick is the fixed-priority pick, not the port after 2
    t.dut = 0; t.req = 4'b1010; t.ack = 4'b0000; t.g = 4'b0010; t.v = 1'b1; t.e = 2'd1;
    t.nm = "post_reset_first_pick";
    apply(t);
    t.dut = 0; t.req = 4'b1010; t.ack = 4'b0010; t.g = 4'b1000; t.v = 1'b1; t.e = 2'd3;
    t.nm = "post_reset_rotate";
    apply(t);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
